// File: rtl/divider_pkg.sv
// Shared types and constants for the stage-3 restoring divider.
package divider;

    localparam int unsigned DIV_ITERATIONS = 26;
    localparam int unsigned DIV_WIDTH      = 26;
    localparam int unsigned CNT_WIDTH      = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state;

endpackage

// File: rtl/fpu_divider_step.sv
// One restoring-division iteration: trial subtract, quotient bit, shifted partial remainder.
module fpu_divider_step
    import divider::*;
(
    input  logic [DIV_WIDTH-1:0] i_remainder,
    input  logic [23:0]          i_divisor,
    output logic [DIV_WIDTH-1:0] o_remainder,
    output logic                 o_quotient_bit
);

    // One extra bit so the borrow is an unsigned compare; a zero divisor then yields all ones.
    logic [DIV_WIDTH:0]   w_diff;
    logic [DIV_WIDTH-1:0] w_keep;

    // Subtract, pick the restored or reduced remainder, then shift it for the next step.
    always_comb begin
        w_diff         = {1'b0, i_remainder} - {3'b000, i_divisor};
        o_quotient_bit = ~w_diff[DIV_WIDTH];
        w_keep         = o_quotient_bit ? w_diff[DIV_WIDTH-1:0] : i_remainder;
        o_remainder    = w_keep << 1;
    end

endmodule

// File: rtl/fpu_stage3_divider.sv
// Stage-3 FPU fraction divider: 26-iteration restoring division with pipeline stall control.
module fpu_stage3_divider
    import divider::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [23:0]          dividend,
    input  logic [23:0]          divisor,
    output logic                 stall,
    output logic                 busy,
    output logic                 done,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic                 sticky
);

    state                 r_state;
    state                 w_state_next;
    logic [CNT_WIDTH-1:0] r_count;
    logic [DIV_WIDTH-1:0] r_remainder;
    logic [23:0]          r_divisor;
    logic [DIV_WIDTH-2:0] r_quo_work;
    logic [DIV_WIDTH-1:0] r_quotient;
    logic                 r_sticky;

    logic [DIV_WIDTH-1:0] w_step_rem;
    logic                 w_step_qbit;
    logic                 w_accept;
    logic                 w_last;

    fpu_divider_step u_step (
        .i_remainder    (r_remainder),
        .i_divisor      (r_divisor),
        .o_remainder    (w_step_rem),
        .o_quotient_bit (w_step_qbit)
    );

    assign w_accept = (r_state == IDLE) && start && !abort;
    // Final iteration that commits results; an abort here discards them.
    assign w_last   = (r_state == DIVIDE) && (r_count == '0) && !abort;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; abort wins over everything.
    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE:    if (start) w_state_next = DIVIDE;
                DIVIDE:  if (r_count == '0) w_state_next = DONE;
                DONE:    w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Output decode.
    always_comb begin
        busy  = (r_state != IDLE);
        stall = (r_state == DIVIDE) || w_accept;
        done  = (r_state == DONE);
    end

    // Iteration datapath: operand load on accept, one step per DIVIDE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count     <= '0;
            r_remainder <= '0;
            r_divisor   <= '0;
            r_quo_work  <= '0;
        end else if (w_accept) begin
            r_count     <= CNT_WIDTH'(DIV_ITERATIONS - 1);
            r_remainder <= {2'b00, dividend};
            r_divisor   <= divisor;
            r_quo_work  <= '0;
        end else if (r_state == DIVIDE) begin
            r_count     <= r_count - 1'b1;
            r_remainder <= w_step_rem;
            r_quo_work  <= {r_quo_work[DIV_WIDTH-3:0], w_step_qbit};
        end
    end

    // Result registers, updated only on the transition into DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_quotient <= '0;
            r_sticky   <= 1'b0;
        end else if (w_last) begin
            r_quotient <= {r_quo_work, w_step_qbit};
            r_sticky   <= |w_step_rem;
        end
    end

    assign quotient = r_quotient;
    assign sticky   = r_sticky;

endmodule

// File: tb/tb_fpu_stage3_divider.sv
// Randomized self-checking bench for fpu_stage3_divider against an arithmetic quotient model.
module tb_fpu_stage3_divider;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [23:0] dividend;
    logic [23:0] divisor;
    logic        stall;
    logic        busy;
    logic        done;
    logic [25:0] quotient;
    logic        sticky;

    int n_checks;
    int n_errors;
    logic [25:0] last_q;
    logic        last_s;

    fpu_stage3_divider dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .abort    (abort),
        .dividend (dividend),
        .divisor  (divisor),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .sticky   (sticky)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Quotient = floor(A * 2^25 / B) as a [x.25] number; sticky = inexact.
    task automatic ref_div(input logic [23:0] a, input logic [23:0] b,
                           output logic [25:0] q, output logic s);
        longint unsigned num;
        num = longint'(a) << 25;
        if (b == 24'd0) begin
            q = 26'h3FFFFFF;
            s = (a != 24'd0);
        end else begin
            q = 26'(num / longint'(b));
            s = ((num % longint'(b)) != 0);
        end
    endtask

    task automatic run_div(input logic [23:0] a, input logic [23:0] b, input bit hold,
                           input string tag);
        logic [25:0] exp_q;
        logic        exp_s;
        int          done_at;
        int          done_cnt;
        int          stall_cnt;
        ref_div(a, b, exp_q, exp_s);
        @(posedge clk);
        #1;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        abort    = 1'b0;
        done_at   = -1;
        done_cnt  = 0;
        stall_cnt = 0;
        for (int c = 0; c <= 27; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
                if (!hold) start = 1'b0;
            end
            #1;
            if (stall) stall_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (c == 0) check_eq({tag, "_stall_accept"}, 32'(stall), 32'd1);
            if (c == 1) check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        end
        check_eq({tag, "_latency"}, 32'(done_at), 32'd27);
        check_eq({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check_eq({tag, "_stall_cycles"}, 32'(stall_cnt), 32'd27);
        check_eq({tag, "_quotient"}, 32'(quotient), 32'(exp_q));
        if (b != 24'd0) check_eq({tag, "_sticky"}, 32'(sticky), 32'(exp_s));
        last_q = exp_q;
        last_s = exp_s;
        start  = 1'b0;
    endtask

    initial begin
        logic [23:0] ra;
        logic [23:0] rb;
        int          pulses;
        n_checks = 0;
        n_errors = 0;
        last_q   = '0;
        last_s   = 1'b0;
        reset_n  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        dividend = '0;
        divisor  = '0;

        #12;
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_stall", 32'(stall), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_quotient", 32'(quotient), 32'd0);
        check_eq("reset_sticky", 32'(sticky), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        run_div(24'h800000, 24'h800000, 1'b0, "one_by_one");
        run_div(24'hC00000, 24'h800000, 1'b0, "1p5_by_one");
        run_div(24'h800000, 24'hC00000, 1'b0, "one_by_1p5");
        run_div(24'hFFFFFF, 24'h800000, 1'b0, "max_by_one");
        run_div(24'h000000, 24'h9ABCDE, 1'b0, "zero_dividend");
        run_div(24'h812345, 24'h000000, 1'b0, "zero_divisor");

        // Start held through a whole operation, then the next one follows straight away.
        run_div(24'hA00000, 24'hE00000, 1'b1, "held_first");
        run_div(24'hF00000, 24'h900000, 1'b0, "held_next");

        for (int i = 0; i < 16; i++) begin
            ra = 24'h800000 | 24'($urandom);
            rb = 24'h800000 | 24'($urandom);
            run_div(ra, rb, (i % 4) == 3, $sformatf("rand%0d", i));
        end

        // Abort has priority over start in IDLE.
        @(posedge clk);
        #1;
        start    = 1'b1;
        abort    = 1'b1;
        dividend = 24'hC00000;
        divisor  = 24'h800000;
        #1;
        check_eq("abort_idle_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        #1;
        check_eq("abort_idle_busy", 32'(busy), 32'd0);

        // Abort in DIVIDE cycle 10.
        @(posedge clk);
        #1;
        dividend = 24'h800000;
        divisor  = 24'hC00000;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        abort = 1'b1;
        #1;
        check_eq("abort_div_busy_before", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        #1;
        check_eq("abort_div_busy", 32'(busy), 32'd0);
        check_eq("abort_div_stall", 32'(stall), 32'd0);
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            if (done) pulses++;
            @(posedge clk);
            #2;
        end
        check_eq("abort_div_no_done", 32'(pulses), 32'd0);
        check_eq("abort_div_quotient", 32'(quotient), 32'(last_q));
        check_eq("abort_div_sticky", 32'(sticky), 32'(last_s));

        // Reset in DIVIDE cycle 5.
        @(posedge clk);
        #1;
        dividend = 24'hC00000;
        divisor  = 24'hA00000;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("rst_div_busy", 32'(busy), 32'd0);
        check_eq("rst_div_stall", 32'(stall), 32'd0);
        check_eq("rst_div_done", 32'(done), 32'd0);
        check_eq("rst_div_quotient", 32'(quotient), 32'd0);
        check_eq("rst_div_sticky", 32'(sticky), 32'd0);
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #2;
            if (done) pulses++;
        end
        check_eq("rst_div_no_done", 32'(pulses), 32'd0);
        #1;
        reset_n = 1'b1;
        run_div(24'hC00000, 24'hA00000, 1'b0, "after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
